// File: rtl/bcd_fnd_scanner.sv
// Time-multiplexed 3-digit common-anode 7-segment scanner fed from packed BCD.
// Optional macro FND_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bcd_fnd_scanner #(
   parameter int DIV = 50000,
   parameter int GAP = 4
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic [11:0] iBCD,
   input  logic        iLOAD,
   output logic [6:0]  oSEG,
   output logic [2:0]  oDIGIT
);

   localparam int CMAX = (DIV > GAP) ? DIV : GAP;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

   typedef enum logic {BLANK, DRIVE} state_t;

   state_t         state, state_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic [1:0]     idx, idx_n;
   logic [11:0]    shadow, disp, disp_n;
   logic [6:0]     seg_n;
   logic [2:0]     digit_n;
   logic [3:0]     nib;
   logic           hide;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = 7'h06;
      endcase
   endfunction

   // Digit decode looks at the shadow word because it becomes the display word on DRIVE entry.
   always_comb begin
      case (idx)
         2'd0:    nib = shadow[3:0];
         2'd1:    nib = shadow[7:4];
         default: nib = shadow[11:8];
      endcase
`ifdef FND_LEADING_ZERO_BLANK_EN
      hide = ((idx == 2'd2) && (shadow[11:8] == 4'd0)) ||
             ((idx == 2'd1) && (shadow[11:4] == 8'd0));
`else
      hide = 1'b0;
`endif
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt + CW'(1);
      idx_n   = idx;
      disp_n  = disp;
      seg_n   = oSEG;
      digit_n = oDIGIT;
      case (state)
         BLANK: begin
            if (cnt == GAP_LAST) begin
               state_n = DRIVE;
               cnt_n   = '0;
               disp_n  = shadow;
               digit_n = ~(3'b001 << idx);
               seg_n   = hide ? 7'h7F : seg7(nib);
            end
         end
         DRIVE: begin
            if (cnt == DIV_LAST) begin
               state_n = BLANK;
               cnt_n   = '0;
               idx_n   = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
               digit_n = '1;
               seg_n   = '1;
            end
         end
         default: begin
            state_n = BLANK;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state  <= BLANK;
         cnt    <= '0;
         idx    <= '0;
         shadow <= '0;
         disp   <= '0;
         oSEG   <= '1;
         oDIGIT <= '1;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         idx    <= idx_n;
         disp   <= disp_n;
         oSEG   <= seg_n;
         oDIGIT <= digit_n;
         if (iLOAD)
            shadow <= iBCD;
      end
   end

endmodule

// File: tb/tb_bcd_fnd_scanner.sv
// Randomized bench for bcd_fnd_scanner against a slot-arithmetic reference model.
module tb_bcd_fnd_scanner;

   localparam int DIV = 4;
   localparam int GAP = 2;
   localparam int P   = DIV + GAP;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] bcd = '0;
   logic        load = 1'b0;
   logic [6:0]  seg;
   logic [2:0]  digit;

   int checks = 0;
   int errors = 0;

   int          k = 0;
   logic [11:0] m_shadow = '0;
   logic [11:0] m_disp = '0;

   localparam logic [6:0] SEGTAB [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   bcd_fnd_scanner #(.DIV(DIV), .GAP(GAP)) dut (
      .iCLK(clk), .iRST(rst), .iBCD(bcd), .iLOAD(load), .oSEG(seg), .oDIGIT(digit)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at k=%0d: got %h expected %h", tag, k, got, exp);
      end
   endtask

   // Digit slot being driven after k edges since reset, or -1 when dark.
   function automatic int slot(input int kk);
      if (kk < GAP) return -1;
      if (((kk - GAP) % P) >= DIV) return -1;
      return ((kk - GAP) / P) % 3;
   endfunction

   task automatic step(input logic r, input logic l, input logic [11:0] v);
      int          s;
      logic [3:0]  n;
      logic [6:0]  eseg;
      logic [2:0]  edig;
      logic        blank;
      @(negedge clk);
      rst = r; load = l; bcd = v;
      @(posedge clk);
      if (r) begin
         k = 0; m_shadow = '0; m_disp = '0;
      end else begin
         k++;
         if (k >= GAP && ((k - GAP) % P) == 0) m_disp = m_shadow;
         if (l) m_shadow = v;
      end
      #1;
      s = slot(k);
      if (s < 0) begin
         eseg = 7'h7F; edig = 3'b111;
      end else begin
         n = 4'((m_disp >> (4 * s)) & 12'hF);
         blank = 1'b0;
`ifdef FND_LEADING_ZERO_BLANK_EN
         if (s == 2 && m_disp[11:8] == 0) blank = 1'b1;
         if (s == 1 && m_disp[11:8] == 0 && m_disp[7:4] == 0) blank = 1'b1;
`endif
         eseg = blank ? 7'h7F : ((n > 9) ? 7'h06 : SEGTAB[n]);
         edig = ~(3'b001 << s);
      end
      check("seg", {5'b0, seg}, {5'b0, eseg});
      check("digit", {9'b0, digit}, {9'b0, edig});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'h000);
   endtask

   task automatic wait_slot(input int d);
      int tries = 0;
      while (slot(k) != d && tries < 100) begin
         step(1'b0, 1'b0, 12'h000);
         tries++;
      end
      check("wait_slot", 12'(slot(k) == d), 12'd1);
   endtask

   initial begin
      logic [11:0] v;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 12'h000);
      step(1'b0, 1'b1, 12'h255);
      run(36);
      wait_slot(0);
      step(1'b0, 1'b1, 12'h123);
      run(40);
      step(1'b0, 1'b1, 12'h0A3);
      run(40);
      step(1'b0, 1'b1, 12'h007);
      run(40);
      wait_slot(1);
      run(1);
      step(1'b1, 1'b0, 12'h000);
      run(20);
      // back-to-back loads: last wins
      step(1'b0, 1'b1, 12'h456);
      step(1'b0, 1'b1, 12'h789);
      run(40);
      // reset beats load
      step(1'b1, 1'b1, 12'h999);
      run(25);
      for (int i = 0; i < 2000; i++) begin
         v = 12'($urandom);
         if ($urandom_range(0, 3) == 0) v[11:8] = 4'd0;
         if ($urandom_range(0, 3) == 0) v[7:4] = 4'd0;
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), v);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_fnd_scanner.md
# bcd_fnd_scanner

Time-multiplexed 3-digit 7-segment (FND) driver that sits directly downstream of the binary-to-BCD converter. It captures the converter's 12-bit packed BCD word (hundreds/tens/ones) on a load strobe. It then scans the three digits one at a time, with a blanking gap between digits to suppress ghosting. Segment and digit-enable outputs are registered and drive the board's common-anode display pins directly.

## Interface
- `DIV`, default 50000: cycles each digit is driven (on-time); legal range ≥ 1.
- `GAP`, default 4: cycles all digits are off between consecutive digits; legal range ≥ 1.
- `iCLK  input  1`: single clock; all state changes on the rising edge.
- `iRST  input  1`: reset, synchronous and active-high.
- `iBCD  input  12`: packed BCD, [11:8] hundreds, [7:4] tens, [3:0] ones.
- `iLOAD  input  1`: capture strobe for iBCD, sampled every edge.
- `oSEG  output  7`: segments, active-low, bit order gfedcba.
- `oDIGIT  output  3`: digit enables, active-low one-hot. Bit 0 is ones, bit 1 is tens, bit 2 is hundreds.

## Operation
- Registers:
  - shadow word: captured iBCD.
  - display word: value being scanned.
  - digit index 0..2.
  - cycle counter, wide enough for max(DIV, GAP).
  - state.
- States:
  - BLANK: oDIGIT = 3'b111, oSEG = 7'h7F.
  - DRIVE: oDIGIT has bit[index] low, oSEG = pattern of the indexed nibble.
- Transitions:
  - BLANK → DRIVE after GAP cycles in BLANK. On entry to DRIVE, the display word ← shadow word.
  - DRIVE → BLANK after DIV cycles in DRIVE. The index increments on this transition, 2 wraps to 0.
  - The counter clears on every transition.
- Load: iLOAD=1 at an edge sets shadow ← iBCD.
  - Back-to-back loads: last one wins.
  - A load never changes the digit currently being driven. The new value appears from the next DRIVE entry (tear-free).
- Segment encoding (gfedcba, active-low):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19.
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Nibbles A–F are illegal BCD and display 'E' = 7'h06.
- A blanked digit keeps its enable slot (uniform duty cycle) with oSEG = 7'h7F.
- Reset mid-operation: every register returns to its reset value at the next edge, whatever the state or counter value.

## Timing
- Reset values:
  - oSEG = 7'h7F, oDIGIT = 3'b111.
  - shadow and display words = 12'h000.
  - index = 0, state = BLANK, counter = 0.
- Outputs are registered. Each output change coincides with the state transition edge, with no combinational path from iBCD or iLOAD.
- Each edge with iRST=0 is one cycle of the current state.
- oDIGIT[0] first goes low at the GAP-th edge after the last reset edge.
- Per digit: exactly DIV cycles driven, then GAP cycles dark.
- Frame period = 3·(DIV+GAP) cycles, order ones → tens → hundreds → ones.
- Load-to-display latency: at most DIV+GAP cycles until the next DRIVE entry. The full new value is visible after at most one additional frame.
- If iLOAD is sampled on the same edge as a BLANK→DRIVE transition, the display word takes the pre-load shadow word, and the new value waits for the following DRIVE.
- iRST has priority over iLOAD.

## Configuration
- `FND_LEADING_ZERO_BLANK_EN` defined:
  - Hundreds digit is blanked when hundreds = 0.
  - Tens digit is blanked when hundreds = 0 and tens = 0.
  - Ones digit is never blanked.
  - Illegal nibbles count as nonzero.
  - The decision uses the display word.
- Macro undefined: all three digits are always shown, including leading zeros (7'h40).

## Test plan
- Reset, DIV=4, GAP=2: assert iRST for 3 edges → oSEG=7'h7F, oDIGIT=3'b111. After release, oDIGIT=3'b110 after 2 cycles for 4 cycles; frame = 18 cycles.
- Load 12'h255 and run 2 frames → ones and tens show 7'h12 on 3'b110 / 3'b101; hundreds shows 7'h24 on 3'b011; gaps show 7'h7F / 3'b111.
- Load 12'h123 during ones DRIVE while showing 12'h255 → current ones stays 7'h12 until its DRIVE ends. The next tens DRIVE shows 7'h24 and hundreds shows 7'h79.
- Load 12'h0A3 → tens shows 'E' 7'h06, ones shows 7'h30.
- Load 12'h007 → ones shows 7'h78. With FND_LEADING_ZERO_BLANK_EN, tens and hundreds show 7'h7F while their enables still assert. Without the macro, tens and hundreds show 7'h40.
- Assert iRST mid-DRIVE of tens → next edge oSEG=7'h7F, oDIGIT=3'b111, display word 12'h000. Scan restarts at ones after GAP cycles and shows 7'h40.
